// File: rtl/ws_pkg.sv
// Shared types and constants for the whitespace-program fetch unit.
// Pure definitions; no timing or flow-control behaviour.
package ws_pkg;

    localparam int ADDR_W_DEF = 10;

    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_TAB = 8'h09;
    localparam logic [7:0] ASCII_LF  = 8'h0a;
    localparam logic [7:0] ASCII_NUL = 8'h00;

    typedef enum logic [1:0] {
        TOK_SP  = 2'd0,
        TOK_TAB = 2'd1,
        TOK_LF  = 2'd2
    } tok_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        OUT   = 2'd2,
        HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/ws_char_class.sv
// Classifies a program byte as token, terminator or comment.
// Purely combinational; no flow control.
module ws_char_class
    import ws_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_is_tok,
    output tok_e       o_tok,
    output logic       o_is_end
);

    always_comb begin
        o_is_tok = 1'b0;
        o_tok    = TOK_SP;
        o_is_end = 1'b0;
        case (i_byte)
            ASCII_SP:  begin o_is_tok = 1'b1; o_tok = TOK_SP;  end
            ASCII_TAB: begin o_is_tok = 1'b1; o_tok = TOK_TAB; end
            ASCII_LF:  begin o_is_tok = 1'b1; o_tok = TOK_LF;  end
            ASCII_NUL: o_is_end = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: rtl/ws_fetch.sv
// Fetches program bytes and emits SP/TAB/LF tokens, skipping comment bytes.
// Token appears 2 cycles after fetch start (+2 per comment); held until tok_ready.
module ws_fetch
    import ws_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              tok_valid,
    input  logic              tok_ready,
    output logic [1:0]        tok,
    output logic [ADDR_W-1:0] tok_pc,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic              halted
);

    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_tok_pc;
    tok_e              r_tok;
    logic              r_tok_valid;
    logic              r_halted;

    logic              w_is_tok;
    logic              w_is_end;
    tok_e              w_tok;
    logic              w_latch_tok;
    logic              w_inc_pc;
    logic              w_set_halt;
    logic              w_handshake;

    ws_char_class u_class (
        .i_byte   (mem_rdata),
        .o_is_tok (w_is_tok),
        .o_tok    (w_tok),
        .o_is_end (w_is_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A jump overrides whatever the current state would do next.
    always_comb begin
        w_next_state = r_state;
        if (jmp_valid) begin
            w_next_state = FETCH;
        end else begin
            case (r_state)
                FETCH: w_next_state = DATA;
                DATA: begin
                    if (w_is_tok)      w_next_state = OUT;
                    else if (w_is_end) w_next_state = HALT;
                    else               w_next_state = FETCH;
                end
                OUT:   if (tok_ready) w_next_state = FETCH;
                HALT:  w_next_state = HALT;
            endcase
        end
    end

    always_comb begin
        w_latch_tok = 1'b0;
        w_inc_pc    = 1'b0;
        w_set_halt  = 1'b0;
        w_handshake = 1'b0;
        if (!jmp_valid && r_state == DATA) begin
            w_latch_tok = w_is_tok;
            w_inc_pc    = !w_is_end;
            w_set_halt  = w_is_end;
        end
        if (r_state == OUT && r_tok_valid && tok_ready) begin
            w_handshake = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_tok_pc    <= '0;
            r_tok       <= TOK_SP;
            r_tok_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else if (jmp_valid) begin
            r_pc        <= jmp_addr;
            r_tok_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            if (w_inc_pc) begin
                r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (w_latch_tok) begin
                r_tok       <= w_tok;
                r_tok_pc    <= r_pc;
                r_tok_valid <= 1'b1;
            end else if (w_handshake) begin
                r_tok_valid <= 1'b0;
            end
            if (w_set_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign mem_addr  = r_pc;
    assign mem_wen   = 1'b0;
    assign mem_wdata = 8'h00;
    assign tok_valid = r_tok_valid;
    assign tok       = r_tok;
    assign tok_pc    = r_tok_pc;
    assign halted    = r_halted;

endmodule

// File: tb/tb_ws_fetch.sv
// Randomised and directed bench for ws_fetch against a token-level program model.
module tb_ws_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] mem_addr;
    logic       mem_wen;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       tok_valid;
    logic       tok_ready = 1'b0;
    logic [1:0] tok;
    logic [9:0] tok_pc;
    logic       jmp_valid = 1'b0;
    logic [9:0] jmp_addr = '0;
    logic       halted;

    logic [7:0] mem [1024];

    int checks = 0;
    int errors = 0;

    ws_fetch #(.ADDR_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok       (tok),
        .tok_pc    (tok_pc),
        .jmp_valid (jmp_valid),
        .jmp_addr  (jmp_addr),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program model: where the next token (or terminator) lives and when it must show.
    logic        live = 1'b0;
    int unsigned cyc = 0;
    int unsigned m_due = 0;
    logic [9:0]  exp_pc = '0;
    logic [1:0]  exp_tok = '0;
    bit          exp_halt = 1'b0;
    bit          exp_v_prev = 1'b0;

    function automatic bit is_stop(input logic [7:0] b);
        return b == 8'h20 || b == 8'h09 || b == 8'h0a || b == 8'h00;
    endfunction

    task automatic schedule(input logic [9:0] sp, input int unsigned sc);
        logic [9:0] p = sp;
        int k = 0;
        while (k < 1024 && !is_stop(mem[p])) begin
            p = p + 10'd1;
            k++;
        end
        exp_pc   = p;
        exp_halt = (mem[p] == 8'h00);
        exp_tok  = (mem[p] == 8'h09) ? 2'd1 : (mem[p] == 8'h0a) ? 2'd2 : 2'd0;
        m_due    = sc + 2 * (k + 1);
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        chk("mem_wen", {31'b0, mem_wen}, 32'd0);
        chk("mem_wdata", {24'b0, mem_wdata}, 32'd0);
        if (!rst_n) begin
            live = 1'b1;
            schedule(10'd0, cyc);
            exp_v_prev = 1'b0;
            chk("rst_tok_valid", {31'b0, tok_valid}, 32'd0);
            chk("rst_halted", {31'b0, halted}, 32'd0);
            chk("rst_tok", {30'b0, tok}, 32'd0);
            chk("rst_tok_pc", {22'b0, tok_pc}, 32'd0);
            chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
        end else if (live) begin
            if (jmp_valid) begin
                schedule(jmp_addr, cyc);
            end else if (exp_v_prev && tok_ready) begin
                schedule(exp_pc + 10'd1, cyc);
            end
            if (cyc >= m_due && exp_halt) begin
                chk("halt_valid", {31'b0, tok_valid}, 32'd0);
                chk("halt_flag", {31'b0, halted}, 32'd1);
                chk("halt_addr", {22'b0, mem_addr}, {22'b0, exp_pc});
            end else if (cyc >= m_due) begin
                chk("tok_valid", {31'b0, tok_valid}, 32'd1);
                chk("tok", {30'b0, tok}, {30'b0, exp_tok});
                chk("tok_pc", {22'b0, tok_pc}, {22'b0, exp_pc});
                chk("out_addr", {22'b0, mem_addr}, {22'b0, exp_pc + 10'd1});
                chk("out_halted", {31'b0, halted}, 32'd0);
            end else begin
                chk("idle_valid", {31'b0, tok_valid}, 32'd0);
                chk("idle_halted", {31'b0, halted}, 32'd0);
            end
            exp_v_prev = (cyc >= m_due) && !exp_halt;
        end
    end

    task automatic hold_reset();
        @(negedge clk);
        rst_n = 1'b0;
        jmp_valid = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_all(input logic [7:0] b);
        for (int i = 0; i < 1024; i++) mem[i] = b;
    endtask

    task automatic wait_tok(input int budget);
        int n = 0;
        while (!tok_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_tok", {31'b0, tok_valid}, 32'd1);
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_halt", {31'b0, halted}, 32'd1);
    endtask

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 15);
        if (r < 4)  return 8'h20;
        if (r < 7)  return 8'h09;
        if (r < 10) return 8'h0a;
        if (r == 10) return 8'h00;
        return 8'h30 + 8'($urandom_range(0, 63));
    endfunction

    initial begin
        int n;
        fill_all(8'h00);

        // Basic stream, first-token timing and terminator.
        hold_reset();
        fill_all(8'h41);
        mem[0] = 8'h20; mem[1] = 8'h09; mem[2] = 8'h0a; mem[3] = 8'h00;
        tok_ready = 1'b1;
        release_reset();
        n = 0;
        while (!tok_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        // Visible after two edges, so first acceptance is on the third edge.
        chk("first_valid_cycles", n, 32'd2);
        chk("t1_tok0", {30'b0, tok}, 32'd0);
        chk("t1_pc0", {22'b0, tok_pc}, 32'd0);
        @(negedge clk);
        wait_tok(20);
        chk("t1_tok1", {30'b0, tok}, 32'd1);
        chk("t1_pc1", {22'b0, tok_pc}, 32'd1);
        @(negedge clk);
        wait_tok(20);
        chk("t1_tok2", {30'b0, tok}, 32'd2);
        chk("t1_pc2", {22'b0, tok_pc}, 32'd2);
        @(negedge clk);
        wait_halt(20);
        repeat (5) @(negedge clk);
        chk("t1_halt_novalid", {31'b0, tok_valid}, 32'd0);
        chk("t1_halted", {31'b0, halted}, 32'd1);

        // Comment bytes are skipped.
        hold_reset();
        fill_all(8'h00);
        mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h20; mem[3] = 8'h00;
        release_reset();
        wait_tok(30);
        chk("t2_tok", {30'b0, tok}, 32'd0);
        chk("t2_pc", {22'b0, tok_pc}, 32'd2);
        @(negedge clk);
        wait_halt(20);
        chk("t2_novalid", {31'b0, tok_valid}, 32'd0);

        // Backpressure holds the token stable.
        hold_reset();
        mem[0] = 8'h20; mem[1] = 8'h09; mem[2] = 8'h0a; mem[3] = 8'h00;
        tok_ready = 1'b0;
        release_reset();
        wait_tok(20);
        chk("t3_pc0", {22'b0, tok_pc}, 32'd0);
        tok_ready = 1'b1;
        @(negedge clk);
        tok_ready = 1'b0;
        wait_tok(20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", {31'b0, tok_valid}, 32'd1);
            chk("t3_hold_tok", {30'b0, tok}, 32'd1);
            chk("t3_hold_pc", {22'b0, tok_pc}, 32'd1);
        end
        tok_ready = 1'b1;
        @(negedge clk);
        wait_tok(20);
        chk("t3_next_tok", {30'b0, tok}, 32'd2);
        chk("t3_next_pc", {22'b0, tok_pc}, 32'd2);

        // Jump coincident with a handshake.
        hold_reset();
        fill_all(8'h20);
        tok_ready = 1'b1;
        release_reset();
        wait_tok(20);
        @(negedge clk);
        wait_tok(20);
        jmp_valid = 1'b1;
        jmp_addr = 10'h200;
        @(negedge clk);
        jmp_valid = 1'b0;
        wait_tok(20);
        chk("t4_jmp_pc", {22'b0, tok_pc}, 32'h200);

        // Leave HALT via jump.
        hold_reset();
        fill_all(8'h00);
        mem[0] = 8'h20;
        release_reset();
        wait_halt(30);
        chk("t5_halt_addr", {22'b0, mem_addr}, 32'd1);
        jmp_valid = 1'b1;
        jmp_addr = 10'd0;
        @(negedge clk);
        jmp_valid = 1'b0;
        chk("t5_halt_clear", {31'b0, halted}, 32'd0);
        wait_tok(20);
        chk("t5_restart_pc", {22'b0, tok_pc}, 32'd0);

        // Address wrap, then reset while a token is pending.
        hold_reset();
        fill_all(8'h20);
        tok_ready = 1'b1;
        release_reset();
        for (int i = 0; i <= 1024; i++) begin
            wait_tok(10);
            if (i == 1023) chk("t6_pc_top", {22'b0, tok_pc}, 32'd1023);
            if (i == 1024) chk("t6_pc_wrap", {22'b0, tok_pc}, 32'd0);
            @(negedge clk);
        end
        wait_tok(10);
        tok_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'b0, tok_valid}, 32'd0);
        chk("t6_rst_addr", {22'b0, mem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tok(20);
        chk("t6_restart_pc", {22'b0, tok_pc}, 32'd0);

        // Random programs, backpressure, jumps and reset pulses.
        for (int r = 0; r < 2; r++) begin
            hold_reset();
            for (int i = 0; i < 1024; i++) mem[i] = rand_byte();
            release_reset();
            for (int c = 0; c < 4000; c++) begin
                @(negedge clk);
                tok_ready = ($urandom_range(0, 3) != 0);
                jmp_valid = ($urandom_range(0, 39) == 0);
                jmp_addr  = 10'($urandom_range(0, 1023));
                rst_n     = ($urandom_range(0, 499) != 0);
            end
        end
        @(negedge clk);
        jmp_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
